// File: rtl/prbs_check_sequencer.sv
// prbs_check_sequencer
// Sequences up to DEPTH queued PRBS-15 check jobs through the pattern-check
// datapath. Each job restarts the datapath, runs it for 4*n_eff+CHECK_LAT
// cycles, samples dp_pattern_valid once, and records a per-job pass bit.
//
// Ports
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   push, job_*         : enqueue a job (accepted when !full && !busy)
//   start, abort        : begin the queued run / flush and return to idle
//   full, empty         : queue status
//   busy, done          : run in progress / one-cycle completion pulse
//   result, pass_cnt    : per-job pass bitmap and number of passing jobs
//   err                 : sticky rejected-push flag, cleared by start
//   dp_*                : datapath control and job parameters
//   dp_pattern_valid    : datapath detector output
module prbs_check_sequencer #(
    parameter int DEPTH     = 4,
    parameter int RST_CYC   = 1,
    parameter int CHECK_LAT = 1,
    parameter int GAP_CYC   = 4   // must be >= 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [31:0]        job_pattern,
    input  logic [31:0]        job_bytes,
    input  logic [7:0]         job_n,
    input  logic               start,
    input  logic               abort,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic               done,
    output logic [DEPTH-1:0]   result,
    output logic [2:0]         pass_cnt,
    output logic               err,
    output logic               dp_rst,
    output logic               dp_enable,
    output logic [7:0]         dp_n,
    output logic [31:0]        dp_pattern,
    output logic [31:0]        dp_bytes_in,
    input  logic               dp_pattern_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [10:0]   RST_M1    = 11'(RST_CYC - 1);
    localparam logic [10:0]   GAP_M1    = 11'(GAP_CYC - 1);
    localparam logic [10:0]   CHECK_L   = 11'(CHECK_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_CHECK, S_GAP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [71:0]       mem_q [DEPTH];
    logic [71:0]       mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d, idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       jpat_q, jpat_d, jbytes_q, jbytes_d;
    logic [7:0]        jn_q, jn_d;
    logic [DEPTH-1:0]  result_q, result_d;
    logic [2:0]        pass_q, pass_d;
    logic              err_q, err_d;

    logic              push_ok, push_rej, start_go, pop;
    logic [71:0]       push_word, head;
    logic [10:0]       run_m1;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign pass_cnt = pass_q;
    assign err      = err_q;
    // Datapath is out of reset only while it runs and while its output is sampled.
    assign dp_rst      = (state_q == S_RUN) || (state_q == S_CHECK);
    assign dp_enable   = dp_rst;
    assign dp_n        = jn_q;
    assign dp_pattern  = jpat_q;
    assign dp_bytes_in = jbytes_q;

    assign push_ok   = push && !full && !busy;
    assign push_rej  = push && (full || busy);
    assign start_go  = start && (state_q == S_IDLE) && !abort;
    assign push_word = {job_pattern, job_bytes, job_n};
    // With an empty queue, a push in the same cycle as start is read straight through.
    assign head      = empty ? push_word : mem_q[rd_q];
    // jn_q already holds n_eff (>= 1), so the run length never underflows.
    assign run_m1    = {1'b0, jn_q, 2'b00} + CHECK_L - 11'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        idx_d    = idx_q;
        jpat_d   = jpat_q;
        jbytes_d = jbytes_q;
        jn_d     = jn_q;
        result_d = result_q;
        pass_d   = pass_q;
        err_d    = err_q;
        pop      = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_go) begin
                        result_d = '0;
                        pass_d   = '0;
                        err_d    = 1'b0;
                        idx_d    = '0;
                        if (!empty || push_ok) begin
                            pop     = 1'b1;
                            cnt_d   = RST_M1;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt_q == '0) begin
                        cnt_d   = run_m1;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 11'd1;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) state_d = S_CHECK;
                    else             cnt_d   = cnt_q - 11'd1;
                end
                S_CHECK: begin
                    result_d[idx_q] = dp_pattern_valid;
                    pass_d          = pass_q + {2'b00, dp_pattern_valid};
                    if (!empty) begin
                        cnt_d   = GAP_M1;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        pop     = 1'b1;
                        idx_d   = idx_q + PW'(1);
                        cnt_d   = RST_M1;
                        state_d = S_LOAD;
                    end else begin
                        cnt_d = cnt_q - 11'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            if (push_ok) begin
                mem_d[wr_q] = push_word;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) begin
                jpat_d   = head[71:40];
                jbytes_d = head[39:8];
                jn_d     = (head[7:0] == 8'd0) ? 8'd1 : head[7:0];
                rd_d     = rd_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end

        if (push_rej) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            jpat_q   <= '0;
            jbytes_q <= '0;
            jn_q     <= '0;
            result_q <= '0;
            pass_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            jpat_q   <= jpat_d;
            jbytes_q <= jbytes_d;
            jn_q     <= jn_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_prbs_check_sequencer.sv
// Self-checking bench for prbs_check_sequencer. A small datapath stand-in
// raises dp_pattern_valid only when pattern == bytes_in and the datapath has
// run exactly 4*n+CHECK_LAT enabled cycles since its last reset.
module tb_prbs_check_sequencer;

    localparam int RST_T = 1;
    localparam int CL_T  = 1;
    localparam int GAP_T = 4;
    localparam logic [31:0] PA = 32'h3ACF491E;
    localparam logic [31:0] PB = 32'h4DF1A98B;

    logic        clk, rst, push, start, abort;
    logic [31:0] job_pattern, job_bytes;
    logic [7:0]  job_n;
    logic        full, empty, busy, done, err;
    logic [3:0]  result;
    logic [2:0]  pass_cnt;
    logic        dp_rst, dp_enable, dp_pattern_valid;
    logic [7:0]  dp_n;
    logic [31:0] dp_pattern, dp_bytes_in;

    prbs_check_sequencer #(.DEPTH(4), .RST_CYC(RST_T), .CHECK_LAT(CL_T), .GAP_CYC(GAP_T)) dut (
        .clk(clk), .rst(rst), .push(push), .job_pattern(job_pattern),
        .job_bytes(job_bytes), .job_n(job_n), .start(start), .abort(abort),
        .full(full), .empty(empty), .busy(busy), .done(done), .result(result),
        .pass_cnt(pass_cnt), .err(err), .dp_rst(dp_rst), .dp_enable(dp_enable),
        .dp_n(dp_n), .dp_pattern(dp_pattern), .dp_bytes_in(dp_bytes_in),
        .dp_pattern_valid(dp_pattern_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int stub_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)           stub_cnt <= 0;
        else if (!dp_rst)   stub_cnt <= 0;
        else if (dp_enable) stub_cnt <= stub_cnt + 1;
    end
    assign dp_pattern_valid = dp_rst && (dp_pattern == dp_bytes_in) &&
                              (stub_cnt == 4 * int'(dp_n) + CL_T);

    int done_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst)      done_cnt <= 0;
        else if (done) done_cnt <= done_cnt + 1;
    end

    int tests, fails;

    typedef struct {
        logic [31:0] pat;
        logic [31:0] bytes;
        logic [7:0]  n;
    } job_t;
    job_t mq[$];

    typedef struct {
        logic        push;
        logic        start;
        logic [31:0] pat;
        logic [31:0] bytes;
        logic [7:0]  n;
        logic        acc;
        logic        e_full;
        logic        e_empty;
        logic        e_busy;
        logic        e_err;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] p, input logic [31:0] b, input logic [7:0] n);
        push = 1'b1; job_pattern = p; job_bytes = b; job_n = n;
        step();
        push = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called at cycle lat0 after the start edge; compares latency, bitmap,
    // pass count and the single done pulse with the model queue mq.
    task automatic run_and_check(input string tag, input int lat0);
        int exp_lat, exp_pass, lat, neff, d0;
        logic [3:0] exp_res;
        exp_lat  = 1;
        exp_pass = 0;
        exp_res  = '0;
        d0       = done_cnt;
        foreach (mq[i]) begin
            neff = (mq[i].n == 8'd0) ? 1 : int'(mq[i].n);
            exp_lat += RST_T + 4 * neff + CL_T + 1;
            if (i > 0) exp_lat += GAP_T;
            if (mq[i].pat == mq[i].bytes) begin
                exp_res[i] = 1'b1;
                exp_pass++;
            end
        end
        lat = lat0;
        while (done !== 1'b1 && lat < 3000) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, {28'd0, result}, {28'd0, exp_res});
        chk({tag, " pass_cnt"}, {29'd0, pass_cnt}, 32'(exp_pass));
        step();
        chk({tag, " done width"}, {31'd0, done}, 32'd0);
        chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
        chk({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        mq.delete();
    endtask

    logic rec_rst  [1:31];
    logic rec_done [1:31];

    initial begin
        int dc0, nd, nj;
        logic same;
        logic [31:0] p, b;
        logic [7:0]  n;

        tests = 0; fails = 0;
        rst = 1'b0; push = 1'b0; start = 1'b0; abort = 1'b0;
        job_pattern = '0; job_bytes = '0; job_n = '0;

        tbl[0] = '{1'b1, 1'b0, PA, PA, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, PB, PB, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, PA, PA, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, PB, PB, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, PA, PB, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, PA, PA, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, PA, PA, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst empty", {31'd0, empty}, 32'd1);
        chk("rst full", {31'd0, full}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst err", {31'd0, err}, 32'd0);
        chk("rst result", {28'd0, result}, 32'd0);
        chk("rst pass", {29'd0, pass_cnt}, 32'd0);
        chk("rst dp_rst", {31'd0, dp_rst}, 32'd0);
        chk("rst dp_en", {31'd0, dp_enable}, 32'd0);
        chk("rst dp_n", {24'd0, dp_n}, 32'd0);
        chk("rst dp_pat", dp_pattern, 32'd0);
        chk("rst dp_bytes", dp_bytes_in, 32'd0);
        rst = 1'b1;
        step();

        // Single job, plus a push while busy
        push_job(PA, PA, 8'd2);
        mq.push_back('{PA, PA, 8'd2});
        do_start();
        chk("single load dp_rst", {31'd0, dp_rst}, 32'd0);
        chk("single busy", {31'd0, busy}, 32'd1);
        chk("single empty", {31'd0, empty}, 32'd1);
        step();
        chk("single run dp_rst", {31'd0, dp_rst}, 32'd1);
        chk("single run dp_en", {31'd0, dp_enable}, 32'd1);
        chk("single dp_n", {24'd0, dp_n}, 32'd2);
        chk("single dp_pat", dp_pattern, PA);
        push_job(PB, PB, 8'd1);
        chk("busy push err", {31'd0, err}, 32'd1);
        chk("busy push empty", {31'd0, empty}, 32'd1);
        run_and_check("single", 3);
        chk("err held", {31'd0, err}, 32'd1);

        // Empty start: done next cycle, result cleared, err cleared
        do_start();
        chk("empty start err", {31'd0, err}, 32'd0);
        run_and_check("empty", 1);

        // n = 0 behaves as n = 1
        push_job(PA, PA, 8'd0);
        mq.push_back('{PA, PA, 8'd0});
        do_start();
        run_and_check("n0", 1);

        // Two jobs: gap and single done
        push_job(PA, PA, 8'd2);
        push_job(PA, PB, 8'd2);
        do_start();
        for (int c = 1; c <= 31; c++) begin
            rec_rst[c]  = dp_rst;
            rec_done[c] = done;
            step();
        end
        chk("two load0", {31'd0, rec_rst[1]}, 32'd0);
        chk("two run0", {31'd0, rec_rst[2]}, 32'd1);
        for (int c = 12; c <= 16; c++) chk("two gap dp_rst", {31'd0, rec_rst[c]}, 32'd0);
        chk("two run1", {31'd0, rec_rst[17]}, 32'd1);
        chk("two done early", {31'd0, rec_done[26]}, 32'd0);
        chk("two done", {31'd0, rec_done[27]}, 32'd1);
        nd = 0;
        for (int c = 1; c <= 31; c++) if (rec_done[c]) nd++;
        chk("two done count", 32'(nd), 32'd1);
        chk("two result", {28'd0, result}, 32'h1);
        chk("two pass", {29'd0, pass_cnt}, 32'd1);

        // Queue boundary table
        for (int i = 0; i < 7; i++) begin
            push = tbl[i].push; start = tbl[i].start;
            job_pattern = tbl[i].pat; job_bytes = tbl[i].bytes; job_n = tbl[i].n;
            if (tbl[i].acc) mq.push_back('{tbl[i].pat, tbl[i].bytes, tbl[i].n});
            step();
            push = 1'b0; start = 1'b0;
            chk($sformatf("tbl%0d full", i), {31'd0, full}, {31'd0, tbl[i].e_full});
            chk($sformatf("tbl%0d empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("tbl%0d err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
        end
        run_and_check("full4", 1);

        // Abort during RUN of the second of three jobs
        push_job(PA, PA, 8'd2);
        push_job(PA, PA, 8'd2);
        push_job(PB, PB, 8'd2);
        do_start();
        repeat (19) step();
        chk("abort pre dp_rst", {31'd0, dp_rst}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        dc0 = done_cnt;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort empty", {31'd0, empty}, 32'd1);
        chk("abort dp_rst", {31'd0, dp_rst}, 32'd0);
        chk("abort result", {28'd0, result}, 32'h1);
        chk("abort pass", {29'd0, pass_cnt}, 32'd1);
        repeat (40) step();
        chk("abort no done", 32'(done_cnt - dc0), 32'd0);

        // Async reset during GAP
        push_job(PA, PA, 8'd2);
        push_job(PA, PA, 8'd2);
        do_start();
        push_job(PA, PA, 8'd1);
        repeat (10) step();
        chk("gap err set", {31'd0, err}, 32'd1);
        chk("gap result", {28'd0, result}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("arst busy", {31'd0, busy}, 32'd0);
        chk("arst done", {31'd0, done}, 32'd0);
        chk("arst err", {31'd0, err}, 32'd0);
        chk("arst result", {28'd0, result}, 32'd0);
        chk("arst pass", {29'd0, pass_cnt}, 32'd0);
        chk("arst empty", {31'd0, empty}, 32'd1);
        chk("arst dp_rst", {31'd0, dp_rst}, 32'd0);
        chk("arst dp_n", {24'd0, dp_n}, 32'd0);
        chk("arst dp_pat", dp_pattern, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) step();
        chk("arst stays idle", {31'd0, busy}, 32'd0);
        chk("arst no done", 32'(done_cnt), 32'd0);

        // Randomized runs against the queue model
        for (int it = 0; it < 20; it++) begin
            nj   = $urandom_range(0, 4);
            same = (nj > 0) && ($urandom_range(0, 1) == 1);
            for (int j = 0; j < nj; j++) begin
                p = $urandom;
                b = ($urandom_range(0, 1) == 1) ? p : (p ^ (32'h1 << $urandom_range(0, 31)));
                n = 8'($urandom_range(0, 6));
                mq.push_back('{p, b, n});
                if (same && j == nj - 1) begin
                    push = 1'b1; start = 1'b1;
                    job_pattern = p; job_bytes = b; job_n = n;
                    step();
                    push = 1'b0; start = 1'b0;
                end else begin
                    push_job(p, b, n);
                end
            end
            if (!same) do_start();
            run_and_check($sformatf("rnd%0d", it), 1);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prbs_check_sequencer.md
# prbs_check_sequencer

Controller that sequences the PRBS-15 pattern-check datapath (`Top`). A host queues up to 4 check jobs (pattern, bytes_in, n). On `start` the block runs them back to back: it restarts the datapath, runs it for the pattern phase, and samples `pattern_valid` at a fixed cycle. It then reports a per-job pass bitmap.

## Interface
Parameters:
- DEPTH, 4, job queue depth; fixed at 4, and the result width depends on it.
- RST_CYC, 1, cycles `dp_rst` is held low at the start of each job (1..15).
- CHECK_LAT, 1, extra cycles after the 4*n pattern bytes before `pattern_valid` is sampled.
- GAP_CYC, 4, idle cycles between jobs; the datapath is held in reset during the gap.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  enqueue job; accepted only when `!full && !busy`.
- job_pattern  in  32  expected pattern for the job.
- job_bytes  in  32  bytes_in driven to the datapath for the job.
- job_n  in  8  pattern repeat count; 0 is treated as 1.
- start  in  1  begin running queued jobs; ignored when busy.
- abort  in  1  synchronous abort; highest priority.
- full / empty  out  1  queue status.
- busy  out  1  high from the cycle after `start` until `done`.
- done  out  1  one-cycle pulse when all jobs are finished.
- result  out  4  bit i = job i passed; valid while `done` is high and held until the next `start`.
- pass_cnt  out  3  number of passing jobs.
- err  out  1  sticky; set by a push that is rejected (full or busy); cleared by `start`.
- dp_rst  out  1  active-low reset to the datapath.
- dp_enable  out  1  datapath enable.
- dp_n  out  8  datapath n.
- dp_pattern / dp_bytes_in  out  32  datapath pattern and bytes_in.
- dp_pattern_valid  in  1  detector output from the datapath.

## Operation
- Queue: 4-entry FIFO of 72-bit jobs, with 2-bit read/write pointers plus a count. Jobs are indexed 0..3 in push order.
- States: IDLE, LOAD, RUN, CHECK, GAP, DONE.
- IDLE: dp_rst=0 and dp_enable=0.
  - start with empty queue: go to DONE next cycle with result=0.
  - start with a non-empty queue: clear result, pass_cnt, err and the job index; pop the head into the job register; go to LOAD.
- LOAD: dp_rst=0 for RST_CYC cycles. dp_n, dp_pattern and dp_bytes_in come from the job register, which is stable for the whole job. Then go to RUN.
- RUN: dp_rst=1, dp_enable=1. An 11-bit counter counts 4*n_eff + CHECK_LAT cycles, where n_eff = max(job_n, 1). Then go to CHECK.
- CHECK, one cycle:
  - Sample dp_pattern_valid into result[idx] and add it to pass_cnt.
  - If the queue is non-empty, go to GAP; otherwise go to DONE.
- GAP: dp_rst=0, dp_enable=0 for GAP_CYC cycles. Then pop the next job, increment idx, go to LOAD.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- abort, any state: next cycle go to IDLE, flush the queue (empty=1), dp_rst=0, and do not assert done. result and pass_cnt keep their partial values.
- Simultaneous events:
  - push and start in the same IDLE cycle: push is accepted first, so the pushed job is included in the run.
  - push while busy: rejected, err set, queue unchanged.
  - abort and start together: abort wins.

## Timing
- Reset values:
  - State IDLE, queue empty (empty=1, full=0).
  - busy=0, done=0, err=0, result=0, pass_cnt=0.
  - dp_rst=0, dp_enable=0, dp_n=0, dp_pattern=0, dp_bytes_in=0.
- Reset asserted mid-job: all of the above apply immediately (asynchronous).
- start at cycle t:
  - LOAD occupies t+1..t+RST_CYC.
  - RUN starts at t+RST_CYC+1 and lasts 4*n_eff+CHECK_LAT cycles.
  - CHECK follows on the next cycle.
- Per-job cycles: RST_CYC + 4*n_eff + CHECK_LAT + 1, plus GAP_CYC for every job except the last.
- done rises the cycle after the last CHECK.
- The counter does not wrap: maximum 4*255+CHECK_LAT, which fits 11 bits for CHECK_LAT ≤ 1027.
- Queue pointers wrap modulo 4. full is asserted when count=4.

## Test plan
- Single job, defaults: push {3ACF491E, 3ACF491E, n=2}, start at cycle t.
  - dp_rst low at t+1; RUN for 9 cycles; CHECK at t+11; done at t+12.
  - Required: result=0001, pass_cnt=1.
- Two jobs: push {3ACF491E, 3ACF491E, 2} then {3ACF491E, 4DF1A98B, 2}, start.
  - Required: 4-cycle gap with dp_rst=0 between jobs; result=0001, pass_cnt=1; done exactly once.
- Queue boundary: push 4 jobs, then a 5th push.
  - Required: full=1 after the 4th push; err=1 and queue unchanged after the 5th.
  - start clears err; with all 4 jobs matching, result=1111 and pass_cnt=4.
- Degenerate cases:
  - start with an empty queue: done one cycle later, result=0.
  - job_n=0: behaves as n=1, i.e. RUN lasts 5 cycles.
- Abort: abort during RUN of job 1 of 3.
  - Required: IDLE next cycle, empty=1, dp_rst=0, no done pulse, result bit0 retained.
- Async reset: pull rst low during GAP.
  - Required: all outputs take their reset values immediately; after release the block sits in IDLE and needs a new start.
